// File: rtl/load_store_unit_pkg.sv
// Shared types and defaults for the load/store unit: access size encoding,
// FSM state encoding and the default data-memory depth.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } lsu_size_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    RMW_READ  = 3'd2,
    RMW_WRITE = 3'd3,
    WRITE     = 3'd4,
    RESP      = 3'd5
  } lsu_state_t;

  localparam int LSU_MEM_WORDS = 32;

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response channel between the execute stage (master) and the
// load/store unit (slave): valid/ready request, one-cycle response pulse.
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_is_store;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_error;

  modport master (
    output req_valid, req_is_store, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_is_store, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/load_store_unit_align.sv
// Lane handling for the load/store unit: extracts a byte/half/word lane from
// a memory word with sign or zero extension, and merges right-aligned store
// data into the selected lane(s) of a word for read-modify-write.
module lsu_align
  import lsu_pkg::*;
(
  input  lsu_size_t   size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  input  logic [31:0] rdata,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  function automatic logic [31:0] extract_lane(input logic [31:0] word,
                                               input logic [1:0]  ln,
                                               input lsu_size_t   sz,
                                               input logic        uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    b = word[{ln, 3'b000} +: 8];
    h = word[{ln[1], 4'b0000} +: 16];
    case (sz)
      SZ_BYTE: r = uns ? $signed({24'h0, b}) : b;
      SZ_HALF: r = uns ? $signed({16'h0, h}) : h;
      default: r = $signed(word);
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [15:0] wd,
                                             input logic [1:0]  ln,
                                             input lsu_size_t   sz);
    logic [31:0] mask;
    logic [31:0] data;
    case (sz)
      SZ_BYTE: begin
        mask = 32'h0000_00FF << {ln, 3'b000};
        data = {24'h0, wd[7:0]} << {ln, 3'b000};
      end
      SZ_HALF: begin
        mask = 32'h0000_FFFF << {ln[1], 4'b0000};
        data = {16'h0, wd} << {ln[1], 4'b0000};
      end
      default: begin
        mask = 32'h0;
        data = 32'h0;
      end
    endcase
    return (word & ~mask) | (data & mask);
  endfunction

  assign load_data  = extract_lane(rdata, lane, size, is_unsigned);
  assign merge_data = merge_lane(rdata, wdata, lane, size);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the word-wide data memory port.
// Accepts byte/half/word loads and stores, does read-modify-write for
// sub-word stores and returns a one-cycle response pulse.
// Optional: define LSU_WORD0_GUARD_EN to reject stores to word index 0.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = LSU_MEM_WORDS,
  parameter int ADDR_W    = 32
) (
  input  logic              clock,
  input  logic              reset,
  load_store_unit_if.slave  req_if,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t        state;
  lsu_size_t         req_size_c;
  logic [ADDR_W-1:0] word_idx;
  logic              align_err;
  logic              range_err;
  logic              guard_err;
  logic              req_err;
  logic              accept;

  lsu_size_t         size_p0;
  logic [1:0]        lane_p0;
  logic              unsigned_p0;
  logic [15:0]       wdata_p0;

  logic [31:0]       load_data;
  logic [31:0]       merge_data;

  assign req_size_c = lsu_size_t'(req_if.req_size);
  assign word_idx   = req_if.req_addr >> 2;
  assign range_err  = (word_idx >= ADDR_W'(MEM_WORDS));
  assign accept     = req_if.req_valid && req_if.req_ready;

  // request check: alignment and illegal size
  always_comb begin
    align_err = 1'b0;
    case (req_size_c)
      SZ_BYTE:    align_err = 1'b0;
      SZ_HALF:    align_err = req_if.req_addr[0];
      SZ_WORD:    align_err = (req_if.req_addr[1:0] != 2'b00);
      SZ_ILLEGAL: align_err = 1'b1;
      default:    align_err = 1'b1;
    endcase
  end

`ifdef LSU_WORD0_GUARD_EN
  // memory discards writes to word 0, so such stores are refused up front
  assign guard_err = req_if.req_is_store && (word_idx == '0);
`else
  assign guard_err = 1'b0;
`endif

  assign req_err = align_err || range_err || guard_err;

  // stage p0: request fields captured on the accept edge
  always_ff @(posedge clock) begin
    if (accept) begin
      size_p0     <= req_size_c;
      lane_p0     <= req_if.req_addr[1:0];
      unsigned_p0 <= req_if.req_unsigned;
      wdata_p0    <= req_if.req_wdata[15:0];
    end
  end

  lsu_align u_align (
    .size        (size_p0),
    .lane        (lane_p0),
    .is_unsigned (unsigned_p0),
    .rdata       (mem_rdata),
    .wdata       (wdata_p0),
    .load_data   (load_data),
    .merge_data  (merge_data)
  );

  // control FSM with registered handshake and memory strobes; the mem_wdata
  // register doubles as the RMW merge buffer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      req_if.req_ready  <= 1'b1;
      req_if.resp_valid <= 1'b0;
      req_if.resp_error <= 1'b0;
      req_if.resp_rdata <= 32'h0;
      mem_we            <= 1'b0;
      mem_re            <= 1'b0;
      mem_addr          <= '0;
      mem_wdata         <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_if.req_ready <= 1'b0;
            if (req_err) begin
              state             <= RESP;
              req_if.resp_valid <= 1'b1;
              req_if.resp_error <= 1'b1;
              req_if.resp_rdata <= 32'h0;
            end else begin
              mem_addr <= word_idx;
              if (!req_if.req_is_store) begin
                state  <= LOAD;
                mem_re <= 1'b1;
              end else if (req_size_c == SZ_WORD) begin
                state     <= WRITE;
                mem_we    <= 1'b1;
                mem_wdata <= req_if.req_wdata;
              end else begin
                state  <= RMW_READ;
                mem_re <= 1'b1;
              end
            end
          end
        end
        LOAD: begin
          mem_re            <= 1'b0;
          state             <= RESP;
          req_if.resp_valid <= 1'b1;
          req_if.resp_error <= 1'b0;
          req_if.resp_rdata <= load_data;
        end
        RMW_READ: begin
          mem_re    <= 1'b0;
          mem_we    <= 1'b1;
          mem_wdata <= merge_data;
          state     <= RMW_WRITE;
        end
        RMW_WRITE, WRITE: begin
          mem_we            <= 1'b0;
          state             <= RESP;
          req_if.resp_valid <= 1'b1;
          req_if.resp_error <= 1'b0;
          req_if.resp_rdata <= 32'h0;
        end
        RESP: begin
          req_if.resp_valid <= 1'b0;
          req_if.resp_error <= 1'b0;
          req_if.req_ready  <= 1'b1;
          state             <= IDLE;
        end
        default: begin
          state            <= IDLE;
          req_if.req_ready <= 1'b1;
          mem_re           <= 1'b0;
          mem_we           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data memory port.
- Accepts byte/half/word load and store requests from the execute stage over a valid/ready handshake.
- Converts byte addresses to word indices and drives the word-wide data memory (read/write enables, address, write data).
- Performs read-modify-write for sub-word stores, extracts and sign/zero-extends loads, and returns a one-cycle response.

Parameters:
MEM_WORDS, 32, number of 32-bit words in the attached data memory; word index >= MEM_WORDS is out of range
ADDR_W, 32, width of request byte address and memory address port

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  unit idle, request accepted when req_valid && req_ready
req_is_store  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data, right-aligned (low bits used for byte/half)
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  load result, 0 for stores and errors
resp_error  output  1  valid with resp_valid: misaligned, out-of-range or illegal size
mem_addr  output  ADDR_W  word index (req_addr >> 2)
mem_wdata  output  32  full word to write
mem_we  output  1  memory write enable
mem_re  output  1  memory read enable
mem_rdata  input  32  memory read data, combinational from mem_addr/mem_re

Behaviour:
- Reset (async, immediate): state IDLE; req_ready=1; resp_valid=0, resp_error=0; resp_rdata=0; mem_we=0; mem_re=0; mem_addr=0; mem_wdata=0.
- Request registers capture is_store/size/unsigned/addr/wdata on the accept edge.
- FSM states:
  - IDLE: req_ready=1. On accept:
    - error check fails → RESP with resp_error=1.
    - load → LOAD.
    - word store → WRITE.
    - byte/half store → RMW_READ.
  - LOAD: mem_re=1; extracted lane registered into resp_rdata at cycle end → RESP.
  - RMW_READ: mem_re=1; mem_rdata registered into merge buffer → RMW_WRITE.
  - RMW_WRITE: mem_we=1; mem_wdata = buffer with the selected lane(s) replaced by req_wdata low bits → RESP.
  - WRITE: mem_we=1; mem_wdata=req_wdata → RESP.
  - RESP: resp_valid=1 for exactly one cycle; req_ready=0 → IDLE.
- Latency from accept edge to the resp_valid cycle: error 1, load 2, word store 2, sub-word store 3 cycles. The next request can be accepted in the cycle after RESP.
- Error checks:
  - half with addr[0]=1, word with addr[1:0]!=0, or size 11 → error.
  - (req_addr>>2) >= MEM_WORDS → error.
  - An error issues no memory access (mem_re=mem_we=0).
- Lane select: byte lane = addr[1:0] (lane 0 = bits 7:0); half lane = addr[1] (0 = bits 15:0).
- Loads: sign-extend from bit 7/15 unless req_unsigned; word loads ignore req_unsigned.
- mem_re and mem_we are never high in the same cycle; both are 0 outside the LOAD, RMW_READ, RMW_WRITE and WRITE states.
- req_valid while busy is ignored; the requester must hold the request until accepted.
- No response backpressure: resp_valid is a pulse.
- Reset asserted mid-operation: the in-flight request is dropped, no response is issued, and mem_we drops in the same instant. A partially completed RMW leaves memory unchanged because the write occurs only in RMW_WRITE.

Optional Feature:
- LSU_WORD0_GUARD_EN defined: a store whose word index is 0 is rejected as an error (1-cycle RESP, resp_error=1, no memory access), because the data memory discards writes to word 0. Loads from word 0 are unaffected.
- Not defined: word-0 stores are issued normally and complete with resp_error=0.

Decomposition:
- Package lsu_pkg holds:
  - enum lsu_size_t {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILLEGAL};
  - enum lsu_state_t {IDLE, LOAD, RMW_READ, RMW_WRITE, WRITE, RESP};
  - the default MEM_WORDS constant.
- One combinational sub-module, lsu_align, performs lane extraction with sign/zero extension and store lane merge. The FSM stays in load_store_unit.

Test Plan:
- Word 1 preloaded 0x8899AABB; lb at addr 0x5 → resp on cycle +2, rdata 0xFFFFFFAA, error 0; lbu at 0x5 → 0x000000AA.
- lh at 0x6 → 0xFFFF8899; lhu at 0x6 → 0x00008899; lw at 0x4 → 0x8899AABB.
- sh at 0x6 with wdata 0x00001234 → mem_re then mem_we on consecutive cycles; word 1 becomes 0x1234AABB; resp on cycle +3.
- lw at 0x6; sh at 0x3; size 11; lw at 0x80 with MEM_WORDS=32 → resp_error=1 on cycle +1, mem_re=mem_we=0 throughout.
- Reset asserted during RMW_READ of sb at 0x9 → req_ready=1 and mem_we=0 immediately; word 2 unchanged; no resp_valid.
- sw 0xDEADBEEF at addr 0x0 → with LSU_WORD0_GUARD_EN: resp_error=1, no mem_we; without it: one mem_we pulse, resp_error=0.
